alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control-side counterpart of the 8-bit ALU. Accepts opcode/operand instructions over a valid/ready handshake and drives the ALU's a, b and s0..s4 select lines.
- Captures the ALU's z and carry_out into an accumulator and flag registers.
- Runs multi-cycle operations (shift-add multiply) by issuing a sequence of ALU passes.
- Sits between the instruction-issue logic and the combinational ALU.

Parameters:
- WIDTH, 8, datapath width. Only 8 is supported; the parameter exists for lint and documentation only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction present
- instr_ready  output  1  sequencer can accept an instruction
- opcode  input  4  operation code
- operand  input  8  immediate operand
- alu_a  output  8  ALU a input
- alu_b  output  8  ALU b input
- alu_s0, alu_s1, alu_s2, alu_s3, alu_s4  output  1 each  ALU select lines
- alu_z  input  8  ALU result
- alu_carry  input  1  ALU carry_out
- acc  output  8  accumulator
- carry_flag  output  1  carry; 1 means no borrow on subtract
- zero_flag  output  1  last result was zero
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse on an illegal opcode

Behaviour:
- Reset is asynchronous, active-high, on clk domain; clk and rst as named above.
- Reset values: acc=0, carry_flag=0, zero_flag=0, done=0, err=0, state IDLE.
  - instr_ready=0 while rst is high, 1 on the first cycle after release.
  - rst asserted mid-operation aborts it immediately; no done is issued.
- ALU control encoding:
  - {s1,s0}: 00 adder, 01 a AND b, 10 pass a, 11 pass b.
  - s2: adder carry-in.
  - s3: invert b.
  - s4=1: forces the adder b input to 0.
- Idle drive: alu_a=acc, alu_b=0, {s4..s0}=00010.
- Handshake:
  - Accept occurs on a rising edge with instr_valid and instr_ready both high; opcode and operand are latched.
  - instr_ready is high only in IDLE.
  - instr_valid while not ready is ignored, not queued.
- States: IDLE -> EXEC -> IDLE for single-pass ops; IDLE -> MUL (16 cycles) -> IDLE for MUL.
- Single-pass ops use alu_a=acc and alu_b=operand unless noted. Control words are listed as s4 s3 s2 s1 s0:
  - 0 NOP: no EXEC. done pulses the cycle after accept; nothing changes.
  - 1 LDA: 00011. acc<=z; carry unchanged.
  - 2 ADD: 00000.
  - 3 ADC: s2=carry_flag.
  - 4 SUB: 01100.
  - 5 SBB: 01c00, where c=carry_flag.
  - 6 AND: 00001. Carry unchanged.
  - 7 INC: 10100.
  - 8 DEC: alu_b=0x00, 01000.
  - 9 CMP: same as SUB, but acc is unchanged.
  - A MUL: see below.
  - B-F: illegal.
- In EXEC, the ALU lines are driven for one cycle. On the next edge:
  - acc<=alu_z (except CMP).
  - zero_flag<=(alu_z==0).
  - carry_flag<=alu_carry for opcodes 2-5 and 7-9.
  - State returns to IDLE, with done=1 and instr_ready=1 in that same following cycle.
- Accept-edge-to-done latency is 2 edges.
- MUL (acc * operand, low 8 bits, multiplier processed MSB first):
  - Latches m=acc and tmp=0.
  - For each bit i=7..0, run a DBL cycle then an ADDSTEP cycle:
    - DBL: a=tmp, b=tmp, 00000; tmp<=z.
    - ADDSTEP: a=tmp, b=m, s4=!operand[i]; tmp<=z.
  - 16 ALU cycles total, fixed, independent of data.
  - ovf accumulates the OR of alu_carry over all 16 cycles.
  - On the final edge: acc<=z, carry_flag<=ovf, zero_flag<=(z==0).
  - done follows on the next cycle, 17 edges after accept.
- Illegal opcode: no state change. err and done pulse together one cycle after accept.
- A back-to-back accept is allowed on the edge that ends the done cycle.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: opcode A is MUL as specified above.
- Undefined: the MUL state and counter are not built, and opcode A is treated as illegal (err+done, no state change).

Test Plan:
- Reset release, then LDA 0x7F, then ADD 0x01 -> acc=0x80, C=0, Z=0; each done exactly 2 edges after its accept.
- LDA 0x05, SUB 0x05 -> acc=0x00, C=1, Z=1; then SBB 0x01 -> acc=0xFF, C=0, Z=0.
- LDA 0x03, CMP 0x05 -> acc stays 0x03, C=0, Z=0; then AND 0x01 -> acc=0x01, C unchanged (0).
- MUL_EN defined:
  - LDA 0x0C, MUL 0x0D -> acc=0x9C, C=0, done 17 edges after accept, instr_ready low throughout.
  - LDA 0x10, MUL 0x10 -> acc=0x00, C=1, Z=1.
- rst pulsed at cycle 5 of a MUL -> acc=0, flags=0, no done; instr_ready=1 the cycle after release.
- Opcode 0xC (and 0xA with MUL_EN undefined) -> err=1 and done=1 for one cycle; acc and flags unchanged.

Source files
------------

// File: rtl/alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_sequencer                                                  |
// | Purpose  : Control-side sequencer for the 8-bit combinational ALU.        |
// |            Accepts opcode/operand instructions on a valid/ready           |
// |            handshake, drives the ALU a/b/select lines, and captures the   |
// |            ALU result into an accumulator plus carry/zero flags. The      |
// |            multiply runs as 16 fixed ALU passes (shift-add, MSB first).   |
// | Macro    : ALU_SEQ_MUL_EN - builds the MUL state and its counter. When   |
// |            undefined, opcode 0xA is treated as an illegal opcode.         |
// | Ports    : clk, rst (async, active-high)                                  |
// |            instr_valid/instr_ready, opcode[3:0], operand[7:0]            |
// |            alu_a, alu_b, alu_s0..alu_s4 -> ALU ; alu_z, alu_carry <- ALU  |
// |            acc, carry_flag, zero_flag, done (pulse), err (pulse)          |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic             alu_s2,
  output logic             alu_s3,
  output logic             alu_s4,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_carry,
  output logic [WIDTH-1:0] acc,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_SBB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_DEC = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hA;
`endif

  // Select words, ordered {s4, s3, s2, s1, s0}.
  localparam logic [4:0] SEL_IDLE = 5'b00010; // pass a
  localparam logic [4:0] SEL_LDA  = 5'b00011; // pass b
  localparam logic [4:0] SEL_ADD  = 5'b00000;
  localparam logic [4:0] SEL_SUB  = 5'b01100; // a + ~b + 1
  localparam logic [4:0] SEL_AND  = 5'b00001;
  localparam logic [4:0] SEL_INC  = 5'b10100; // a + 0 + 1
  localparam logic [4:0] SEL_DEC  = 5'b01000; // a + ~0 + 0

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       op;
  logic [WIDTH-1:0] opnd;
  logic [4:0]       sel;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] tmp;   // running partial product
  logic [WIDTH-1:0] m;     // multiplicand snapshot of acc
  logic [3:0]       cnt;   // cnt[3:1] = bit step, cnt[0] = 0 DBL / 1 ADDSTEP
  logic             ovf;   // any carry seen during the multiply
  logic [2:0]       bit_idx;

  // Multiplier bits are consumed MSB first.
  assign bit_idx = 3'd7 - cnt[3:1];
`endif

  // ALU drive is decoded from registered state only.
  always_comb begin
    alu_a = acc;
    alu_b = '0;
    sel   = SEL_IDLE;
    case (state)
      S_EXEC: begin
        alu_b = opnd;
        case (op)
          OP_LDA:  sel = SEL_LDA;
          OP_ADD:  sel = SEL_ADD;
          OP_ADC:  sel = {2'b00, carry_flag, 2'b00};
          OP_SUB:  sel = SEL_SUB;
          // carry_flag=1 means "no borrow", so it doubles as the +1.
          OP_SBB:  sel = {2'b01, carry_flag, 2'b00};
          OP_AND:  sel = SEL_AND;
          OP_INC:  sel = SEL_INC;
          OP_DEC: begin
            alu_b = '0;
            sel   = SEL_DEC;
          end
          OP_CMP:  sel = SEL_SUB;
          default: sel = SEL_IDLE;
        endcase
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        alu_a = tmp;
        // DBL adds tmp to itself; ADDSTEP adds m, or zero via s4 when the
        // multiplier bit is clear.
        alu_b = cnt[0] ? m : tmp;
        sel   = {(cnt[0] & ~opnd[bit_idx]), 4'b0000};
      end
`endif
      default: begin
        alu_a = acc;
        alu_b = '0;
        sel   = SEL_IDLE;
      end
    endcase
  end

  assign {alu_s4, alu_s3, alu_s2, alu_s1, alu_s0} = sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op          <= OP_NOP;
      opnd        <= '0;
      acc         <= '0;
      carry_flag  <= 1'b0;
      zero_flag   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      instr_ready <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      tmp         <= '0;
      m           <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            op   <= opcode;
            opnd <= operand;
            case (opcode)
              OP_NOP: done <= 1'b1;
              OP_LDA, OP_ADD, OP_ADC, OP_SUB, OP_SBB,
              OP_AND, OP_INC, OP_DEC, OP_CMP: begin
                state       <= S_EXEC;
                instr_ready <= 1'b0;
              end
`ifdef ALU_SEQ_MUL_EN
              OP_MUL: begin
                state       <= S_MUL;
                instr_ready <= 1'b0;
                m           <= acc;
                tmp         <= '0;
                cnt         <= '0;
                ovf         <= 1'b0;
              end
`endif
              default: begin
                err  <= 1'b1;
                done <= 1'b1;
              end
            endcase
          end
        end
        S_EXEC: begin
          if (op != OP_CMP)
            acc <= alu_z;
          zero_flag <= (alu_z == '0);
          // LDA and AND leave the carry untouched.
          if (op != OP_LDA && op != OP_AND)
            carry_flag <= alu_carry;
          state       <= S_IDLE;
          done        <= 1'b1;
          instr_ready <= 1'b1;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          tmp <= alu_z;
          ovf <= ovf | alu_carry;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            acc         <= alu_z;
            carry_flag  <= ovf | alu_carry;
            zero_flag   <= (alu_z == '0);
            state       <= S_IDLE;
            done        <= 1'b1;
            instr_ready <= 1'b1;
          end
        end
`endif
        default: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_sequencer                                               |
// | Purpose  : Scoreboard bench for alu_sequencer with a behavioural ALU.     |
// |            Directed instructions push hand-computed results; a monitor   |
// |            pops and compares on every done pulse.                         |
// | Macro    : ALU_SEQ_MUL_EN selects the MUL expectations.                  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] opcode = 4'h0;
  logic [7:0] operand = 8'h00;
  logic [7:0] alu_a, alu_b, alu_z;
  logic       alu_s0, alu_s1, alu_s2, alu_s3, alu_s4;
  logic       alu_carry;
  logic [7:0] acc;
  logic       carry_flag, zero_flag, done, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .operand(operand),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_s3(alu_s3), .alu_s4(alu_s4),
    .alu_z(alu_z), .alu_carry(alu_carry),
    .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .done(done), .err(err)
  );

  // Behavioural model of the combinational ALU.
  logic [7:0] bx;
  logic [8:0] sum;
  always_comb begin
    bx  = alu_s4 ? 8'h00 : (alu_s3 ? ~alu_b : alu_b);
    sum = {1'b0, alu_a} + {1'b0, bx} + {8'h00, alu_s2};
    alu_carry = 1'b0;
    case ({alu_s1, alu_s0})
      2'b00: begin alu_z = sum[7:0]; alu_carry = sum[8]; end
      2'b01: alu_z = alu_a & alu_b;
      2'b10: alu_z = alu_a;
      default: alu_z = alu_b;
    endcase
  end

  typedef struct {
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       e;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t  sbq[$];
  string nameq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare on every done pulse.
  exp_t  cur;
  string cur_nm;
  always @(negedge clk) begin
    if (!rst) begin
      if (err && !done) chk("err_without_done", 1, 0);
      if (done) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          cur    = sbq.pop_front();
          cur_nm = nameq.pop_front();
          chk({cur_nm, ".acc"}, {24'h0, acc}, {24'h0, cur.acc});
          chk({cur_nm, ".carry"}, {31'h0, carry_flag}, {31'h0, cur.c});
          chk({cur_nm, ".zero"}, {31'h0, zero_flag}, {31'h0, cur.z});
          chk({cur_nm, ".err"}, {31'h0, err}, {31'h0, cur.e});
          chk({cur_nm, ".latency"}, cyc - cur.acc_cyc + 1, cur.lat);
        end
      end
    end
  end

  // Waits for ready, presents one instruction for the accepting edge, and
  // returns at the negedge after that edge.
  task automatic issue(input string nm, input logic [3:0] op, input logic [7:0] opd,
                       input logic [7:0] eacc, input logic ec, input logic ez,
                       input logic ee, input int lat);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      chk({nm, ".ready_timeout"}, 0, 1);
      return;
    end
    opcode      = op;
    operand     = opd;
    instr_valid = 1'b1;
    e.acc = eacc; e.c = ec; e.z = ez; e.e = ee; e.lat = lat;
    e.acc_cyc = cyc + 1;
    sbq.push_back(e);
    nameq.push_back(nm);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Asserts rst at the current time, checks reset values, then releases.
  task automatic do_reset();
    rst = 1'b1;
    sbq.delete();
    nameq.delete();
    @(negedge clk);
    chk("rst.acc", {24'h0, acc}, 32'h0);
    chk("rst.flags", {30'h0, carry_flag, zero_flag}, 32'h0);
    chk("rst.ready", {31'h0, instr_ready}, 32'h0);
    chk("rst.done_err", {30'h0, done, err}, 32'h0);
    chk("rst.idle_drive", {11'h0, alu_a, alu_b, alu_s4, alu_s3, alu_s2, alu_s1, alu_s0},
        {11'h0, 8'h00, 8'h00, 5'b00010});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready_after_release", {31'h0, instr_ready}, 32'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int w;
    @(negedge clk);
    do_reset();

    issue("lda7f", 4'h1, 8'h7F, 8'h7F, 0, 0, 0, 2);
    issue("add01", 4'h2, 8'h01, 8'h80, 0, 0, 0, 2);
    issue("lda05", 4'h1, 8'h05, 8'h05, 0, 0, 0, 2);
    issue("sub05", 4'h4, 8'h05, 8'h00, 1, 1, 0, 2);
    issue("sbb01", 4'h5, 8'h01, 8'hFF, 0, 0, 0, 2);
    issue("lda03", 4'h1, 8'h03, 8'h03, 0, 0, 0, 2);
    issue("cmp05", 4'h9, 8'h05, 8'h03, 0, 0, 0, 2);
    issue("and01", 4'h6, 8'h01, 8'h01, 0, 0, 0, 2);
    issue("ldaff", 4'h1, 8'hFF, 8'hFF, 0, 0, 0, 2);
    issue("add_wrap", 4'h2, 8'h01, 8'h00, 1, 1, 0, 2);
    issue("adc00", 4'h3, 8'h00, 8'h01, 0, 0, 0, 2);
    issue("inc", 4'h7, 8'hAA, 8'h02, 0, 0, 0, 2);
    issue("dec_a", 4'h8, 8'hAA, 8'h01, 1, 0, 0, 2);
    issue("dec_b", 4'h8, 8'h55, 8'h00, 1, 1, 0, 2);
    issue("dec_c", 4'h8, 8'h00, 8'hFF, 0, 0, 0, 2);
    issue("nop", 4'h0, 8'h33, 8'hFF, 0, 0, 0, 1);
    issue("illegal_c", 4'hC, 8'h44, 8'hFF, 0, 0, 1, 1);
    issue("lda0c", 4'h1, 8'h0C, 8'h0C, 0, 0, 0, 2);
`ifdef ALU_SEQ_MUL_EN
    issue("mul0d", 4'hA, 8'h0D, 8'h9C, 0, 0, 0, 17);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      if (instr_ready) hi++;
      @(negedge clk);
    end
    chk("mul.ready_low_cycles", hi, 0);
    issue("lda10", 4'h1, 8'h10, 8'h10, 0, 0, 0, 2);
    issue("mul10", 4'hA, 8'h10, 8'h00, 1, 1, 0, 17);
    issue("lda55", 4'h1, 8'h55, 8'h55, 1, 0, 0, 2);
    // Abort a multiply in its fifth cycle.
    issue("mul_abort", 4'hA, 8'h03, 8'hFF, 0, 0, 0, 17);
    repeat (4) @(negedge clk);
    do_reset();
`else
    issue("illegal_a", 4'hA, 8'h0D, 8'h0C, 0, 0, 1, 1);
    issue("lda55", 4'h1, 8'h55, 8'h55, 0, 0, 0, 2);
    // Abort a single-pass op during its EXEC cycle.
    issue("add_abort", 4'h2, 8'h01, 8'h56, 0, 0, 0, 2);
    do_reset();
`endif

    issue("lda12", 4'h1, 8'h12, 8'h12, 0, 0, 0, 2);
    issue("add01b", 4'h2, 8'h01, 8'h13, 0, 0, 0, 2);
    // A valid presented while busy must be dropped, not queued.
    chk("busy.ready_low", {31'h0, instr_ready}, 32'h0);
    opcode = 4'hC; operand = 8'h99; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    issue("lda_after_poke", 4'h1, 8'h20, 8'h20, 0, 0, 0, 2);

    w = 0;
    while (sbq.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("drain.outstanding", sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
